// File: rtl/shift_rotate_seq_if.sv
// rtl/shift_rotate_seq_if.sv - start/busy/done handshake and flag outputs of the shift/rotate unit
interface shift_rotate_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [CNT_W-1:0] cnt;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic             cout;
  logic             of;
  logic             zf;
  logic             sf;

  modport master (
    output start, op, a, cnt, cin,
    input  busy, done, r, cout, of, zf, sf
  );

  modport slave (
    input  start, op, a, cnt, cin,
    output busy, done, r, cout, of, zf, sf
  );
endinterface

// File: rtl/shift_rotate_seq.sv
// rtl/shift_rotate_seq.sv - multi-cycle ROL/ROR/RCL/RCR/SHL/SHR/SAR unit, up to STEP bits per clock
module shift_rotate_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter int STEP  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_rotate_seq_if.slave bus
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_RCL = 3'b010;
  localparam logic [2:0] OP_RCR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SAR = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       wop;
  logic [WIDTH-1:0] wr;
  logic             wcf;
  logic [CNT_W-1:0] rem;
  logic             a_msb;
  logic             accept;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] step_r;
  logic             step_cf;
  logic             step_of;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] rem_nxt;
  logic             last;
  logic [WIDTH-1:0] res_r;
  logic             res_cout, res_of, res_zf, res_sf;

  // One single-bit step; result packed as {cf, value}. Pass (111) leaves both untouched.
  function automatic logic [WIDTH:0] shift1(input logic [2:0] op, input logic [WIDTH-1:0] v,
                                            input logic cf);
    case (op)
      OP_ROL:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  return {v[0], v[0], v[WIDTH-1:1]};
      OP_RCL:  return {v[WIDTH-1], v[WIDTH-2:0], cf};
      OP_RCR:  return {v[0], cf, v[WIDTH-1:1]};
      OP_SHL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SHR:  return {v[0], 1'b0, v[WIDTH-1:1]};
      OP_SAR:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: return {cf, v};
    endcase
  endfunction

  assign accept = bus.start && (state != S_RUN);

  always_comb begin
    acc = {wcf, wr};
    for (int i = 0; i < STEP; i++) begin
      if (CNT_W'(i) < rem) acc = shift1(wop, acc[WIDTH-1:0], acc[WIDTH]);
    end
    step_r  = acc[WIDTH-1:0];
    step_cf = acc[WIDTH];
    k       = (rem < CNT_W'(STEP)) ? rem : CNT_W'(STEP);
    rem_nxt = rem - k;
    last    = (rem_nxt == '0);
  end

  always_comb begin
    case (wop)
      OP_ROL, OP_RCL, OP_SHL: step_of = step_r[WIDTH-1] ^ step_cf;
      OP_ROR, OP_RCR:         step_of = step_r[WIDTH-1] ^ step_r[WIDTH-2];
      OP_SHR:                 step_of = a_msb;
      default:                step_of = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = (bus.cnt == '0) ? S_DONE : S_RUN;
        else        state_nxt = S_IDLE;
      end
      S_RUN:   if (last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_RUN);
    bus.done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wop   <= '0;
      wr    <= '0;
      wcf   <= 1'b0;
      rem   <= '0;
      a_msb <= 1'b0;
    end else if (accept) begin
      wop   <= bus.op;
      wr    <= bus.a;
      wcf   <= bus.cin;
      rem   <= bus.cnt;
      a_msb <= bus.a[WIDTH-1];
    end else if (state == S_RUN) begin
      wr  <= step_r;
      wcf <= step_cf;
      rem <= rem_nxt;
    end
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r    <= '0;
      res_cout <= 1'b0;
      res_of   <= 1'b0;
      res_zf   <= 1'b0;
      res_sf   <= 1'b0;
    end else if (accept && bus.cnt == '0) begin
      res_r    <= bus.a;
      res_cout <= bus.cin;
      res_of   <= 1'b0;
      res_zf   <= (bus.a == '0);
      res_sf   <= bus.a[WIDTH-1];
    end else if (state == S_RUN && last) begin
      res_r    <= step_r;
      res_cout <= step_cf;
      res_of   <= step_of;
      res_zf   <= (step_r == '0);
      res_sf   <= step_r[WIDTH-1];
    end
  end

  assign bus.r    = res_r;
  assign bus.cout = res_cout;
  assign bus.of   = res_of;
  assign bus.zf   = res_zf;
  assign bus.sf   = res_sf;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb/tb_shift_rotate_seq.sv - bench for shift_rotate_seq, STEP=1 and STEP=4 instances side by side
module tb_shift_rotate_seq;
  localparam int W  = 16;
  localparam int CW = 5;

  typedef struct {
    logic [W-1:0] r;
    logic         cout;
    logic         of;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    int           cnt;
    logic         cin;
    logic [W-1:0] r;
    logic         cout;
    logic         of;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op_i = '0;
  logic [W-1:0]  a_i = '0;
  logic [CW-1:0] cnt_i = '0;
  logic          cin_i = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;
  vec_t          tbl[14];
  res_t          e;
  logic [2:0]    rop;
  logic [W-1:0]  ra;
  int            rcnt;
  logic          rcin;
  logic          seen;

  always #5 clk = ~clk;

  shift_rotate_seq_if #(.WIDTH(W), .CNT_W(CW)) i1 ();
  shift_rotate_seq_if #(.WIDTH(W), .CNT_W(CW)) i4 ();

  assign i1.start = start;
  assign i1.op    = op_i;
  assign i1.a     = a_i;
  assign i1.cnt   = cnt_i;
  assign i1.cin   = cin_i;
  assign i4.start = start;
  assign i4.op    = op_i;
  assign i4.a     = a_i;
  assign i4.cnt   = cnt_i;
  assign i4.cin   = cin_i;

  shift_rotate_seq #(.WIDTH(W), .CNT_W(CW), .STEP(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  shift_rotate_seq #(.WIDTH(W), .CNT_W(CW), .STEP(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));

  // Reference: whole-count arithmetic on widened values rather than bit-by-bit stepping.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input int cnt,
                                 input logic cin);
    res_t m;
    logic [2*W-1:0] d2;
    logic [2*W+1:0] d3;
    logic [W:0] x;
    logic [63:0] y;
    logic signed [63:0] s;
    int n;
    m.r = a; m.cout = cin; m.of = 1'b0;
    if (cnt == 0) return m;
    case (op)
      3'd0: begin n = cnt % W; d2 = {a, a} << n; m.r = d2[2*W-1:W]; m.cout = m.r[0]; end
      3'd1: begin n = cnt % W; d2 = {a, a} >> n; m.r = d2[W-1:0]; m.cout = m.r[W-1]; end
      3'd2: begin
        x = {cin, a}; n = cnt % (W+1); d3 = {x, x} << n; x = d3[2*W+1:W+1];
        m.cout = x[W]; m.r = x[W-1:0];
      end
      3'd3: begin
        x = {cin, a}; n = cnt % (W+1); d3 = {x, x} >> n; x = d3[W:0];
        m.cout = x[W]; m.r = x[W-1:0];
      end
      3'd4: begin y = {48'b0, a} << cnt; m.r = y[W-1:0]; m.cout = y[W]; end
      3'd5: begin y = {47'b0, a, 1'b0} >> cnt; m.r = y[W:1]; m.cout = y[0]; end
      3'd6: begin s = {{47{a[W-1]}}, a, 1'b0}; s = s >>> cnt; m.r = s[W:1]; m.cout = s[0]; end
      default: ;
    endcase
    case (op)
      3'd0, 3'd2, 3'd4: m.of = m.r[W-1] ^ m.cout;
      3'd1, 3'd3:       m.of = m.r[W-1] ^ m.r[W-2];
      3'd5:             m.of = a[W-1];
      default:          m.of = 1'b0;
    endcase
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents the request for one edge, then scrambles the inputs.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input int cnt, input logic cin);
    op_i = op; a_i = a; cnt_i = CW'(cnt); cin_i = cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i = 3'($urandom); a_i = W'($urandom); cnt_i = CW'($urandom); cin_i = 1'($urandom);
  endtask

  // Returns at the negedge where the slower instance shows done.
  task automatic collect(input string name, input res_t ex, input int cnt, input int glitch);
    int d1, d4, b1, b4, l1, l4;
    logic [W-1:0] h1, h4;
    bit hold_ok;
    l1 = cnt; l4 = (cnt + 3) / 4;
    d1 = -1; d4 = -1; b1 = 0; b4 = 0; hold_ok = 1'b1;
    @(negedge clk);
    h1 = i1.r; h4 = i4.r;
    for (int idx = 0; idx <= 40; idx++) begin
      if (idx > 0) @(negedge clk);
      if (d1 < 0) begin
        if (i1.done) d1 = idx;
        else begin b1 += int'(i1.busy); if (i1.r !== h1) hold_ok = 1'b0; end
      end
      if (d4 < 0) begin
        if (i4.done) d4 = idx;
        else begin b4 += int'(i4.busy); if (i4.r !== h4) hold_ok = 1'b0; end
      end
      if (d1 >= 0 && d4 >= 0) break;
      if (glitch >= 0 && idx == glitch) begin
        start = 1'b1; op_i = 3'd4; a_i = 16'h5A5A; cnt_i = 5'd1; cin_i = 1'b1;
      end
      if (glitch >= 0 && idx == glitch + 1) start = 1'b0;
    end
    start = 1'b0;
    chk({name, " lat1"}, d1, l1);
    chk({name, " lat4"}, d4, l4);
    chk({name, " busy1"}, b1, l1);
    chk({name, " busy4"}, b4, l4);
    chk({name, " hold"}, hold_ok, 1);
    chk({name, " r1"}, i1.r, ex.r);
    chk({name, " r4"}, i4.r, ex.r);
    chk({name, " cf1"}, i1.cout, ex.cout);
    chk({name, " cf4"}, i4.cout, ex.cout);
    chk({name, " of1"}, i1.of, ex.of);
    chk({name, " of4"}, i4.of, ex.of);
    chk({name, " zf1"}, i1.zf, (ex.r == '0));
    chk({name, " zf4"}, i4.zf, (ex.r == '0));
    chk({name, " sf1"}, i1.sf, ex.r[W-1]);
    chk({name, " sf4"}, i4.sf, ex.r[W-1]);
  endtask

  initial begin
    tbl[0]  = '{3'd3, 16'h0001,  1, 1'b1, 16'h8000, 1'b1, 1'b1};
    tbl[1]  = '{3'd4, 16'hBEEF,  0, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    tbl[2]  = '{3'd6, 16'h8000, 20, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[3]  = '{3'd2, 16'h1234, 17, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[4]  = '{3'd0, 16'h8001,  1, 1'b0, 16'h0003, 1'b1, 1'b1};
    tbl[5]  = '{3'd4, 16'h00FF,  6, 1'b0, 16'h3FC0, 1'b0, 1'b0};
    tbl[6]  = '{3'd5, 16'h8001,  1, 1'b0, 16'h4000, 1'b1, 1'b1};
    tbl[7]  = '{3'd4, 16'h0001, 16, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8]  = '{3'd1, 16'h0001,  1, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[9]  = '{3'd7, 16'hABCD,  5, 1'b0, 16'hABCD, 1'b0, 1'b0};
    tbl[10] = '{3'd5, 16'hFFFF, 31, 1'b1, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{3'd0, 16'h1234, 16, 1'b1, 16'h1234, 1'b0, 1'b0};
    tbl[12] = '{3'd3, 16'h0000, 17, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[13] = '{3'd6, 16'h4000, 15, 1'b0, 16'h0000, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset u1", {i1.busy, i1.done, i1.r, i1.cout, i1.of, i1.zf, i1.sf}, 0);
    chk("reset u4", {i4.busy, i4.done, i4.r, i4.cout, i4.of, i4.zf, i4.sf}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      e.r = tbl[i].r; e.cout = tbl[i].cout; e.of = tbl[i].of;
      issue(tbl[i].op, tbl[i].a, tbl[i].cnt, tbl[i].cin);
      collect($sformatf("vec%0d", i), e, tbl[i].cnt, -1);
    end

    // start pulsed mid-RUN with different operands must be ignored
    e = '{16'hFFFF, 1'b1, 1'b0};
    issue(3'd6, 16'h8000, 20, 1'b0);
    collect("glitch", e, 20, 2);

    // second request lands in the DONE cycle of the first
    e = model(3'd0, 16'h8001, 1, 1'b0);
    issue(3'd0, 16'h8001, 1, 1'b0);
    collect("b2b_a", e, 1, -1);
    e = model(3'd5, 16'h8001, 3, 1'b0);
    issue(3'd5, 16'h8001, 3, 1'b0);
    collect("b2b_b", e, 3, -1);

    // reset in the middle of RUN
    issue(3'd4, 16'h00FF, 20, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst u1", {i1.busy, i1.done, i1.r, i1.cout, i1.of, i1.zf, i1.sf}, 0);
    chk("midrst u4", {i4.busy, i4.done, i4.r, i4.cout, i4.of, i4.zf, i4.sf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (i1.done || i4.done || i1.busy || i4.busy) seen = 1'b1;
    end
    chk("midrst nodone", seen, 0);

    for (int i = 0; i < 60; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = W'($urandom);
      rcnt = (i % 8 == 0) ? 0 : int'($urandom_range(0, 31));
      rcin = 1'($urandom);
      e = model(rop, ra, rcnt, rcin);
      issue(rop, ra, rcnt, rcin);
      collect($sformatf("rnd%0d op%0d cnt%0d", i, rop, rcnt), e, rcnt, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
